// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: SHR, SHRA, SHL, ROR, ROL, up to STEP positions per clock.
// Optional carry_out port when SHIFT_CARRY_EN is defined.
module shift_rotate_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef SHIFT_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  localparam int unsigned LW = $clog2(WIDTH);
  localparam int unsigned CW = LW + 1;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       op_q;
  logic [CW-1:0]    n_c;
  logic [CW-1:0]    step_k_c;
  logic             accept_c;
  logic             busy_d, done_d;

  // Move x by k positions; k never exceeds WIDTH, and is below WIDTH for rotates.
  function automatic logic [WIDTH-1:0] shift_by(input logic [2:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [CW-1:0] k);
    logic [WIDTH-1:0] y;
    y = x;
    case (o)
      OP_SHR:  y = x >> k;
      OP_SHRA: y = $unsigned($signed(x) >>> k);
      OP_SHL:  y = x << k;
      OP_ROR:  y = (x >> k) | (x << (CW'(WIDTH) - k));
      OP_ROL:  y = (x << k) | (x >> (CW'(WIDTH) - k));
      default: y = x;
    endcase
    return y;
  endfunction

  // Effective count: rotates wrap, shifts saturate at WIDTH, pass-through ops do nothing.
  always_comb begin
    n_c = '0;
    case (op)
      OP_SHR, OP_SHRA, OP_SHL:
        n_c = (amount >= WIDTH'(WIDTH)) ? CW'(WIDTH) : CW'(amount);
      OP_ROR, OP_ROL:
        n_c = CW'(amount[LW-1:0]);
      default: n_c = '0;
    endcase
  end

  assign accept_c = (state_q == S_IDLE) && start;
  assign step_k_c = (count_q > CW'(STEP)) ? CW'(STEP) : count_q;

  // State register
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (n_c != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (count_q == step_k_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, registered below so busy/done are glitch-free
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Working register and remaining count
  always_comb begin
    work_d  = work_q;
    count_d = count_q;
    if (accept_c) begin
      work_d  = operand;
      count_d = n_c;
    end else if (state_q == S_SHIFT) begin
      work_d  = shift_by(op_q, work_q, step_k_c);
      count_d = count_q - step_k_c;
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      work_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      work_q  <= work_d;
      count_q <= count_d;
      busy    <= busy_d;
      done    <= done_d;
      if (accept_c) op_q <= op;
      if (done_d)   result <= work_d;
    end
  end

`ifdef SHIFT_CARRY_EN
  logic carry_c;
  logic carry_q;

  // Last bit leaving the operand, resolved at accept time from the unshifted value
  always_comb begin
    carry_c = 1'b0;
    if (n_c != '0) begin
      case (op)
        OP_SHR, OP_SHRA, OP_ROR: carry_c = operand[LW'(n_c - CW'(1))];
        OP_SHL, OP_ROL:          carry_c = operand[LW'(CW'(WIDTH) - n_c)];
        default:                 carry_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      carry_q   <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      if (accept_c) carry_q <= carry_c;
      if (done_d)   carry_out <= accept_c ? carry_c : carry_q;
    end
  end
`endif

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit: one STEP=1 and one STEP=4 instance share the inputs.
module tb_shift_rotate_unit;
  localparam int unsigned WIDTH = 32;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  logic             Clock = 1'b0;
  logic             Clear;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] amount;
  logic             busy1, done1, busy4, done4;
  logic [WIDTH-1:0] result1, result4;
`ifdef SHIFT_CARRY_EN
  logic             carry1, carry4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  shift_rotate_unit #(.WIDTH(WIDTH), .STEP(1)) u_dut1 (
    .Clock(Clock), .Clear(Clear), .start(start), .op(op), .operand(operand),
    .amount(amount), .busy(busy1), .done(done1), .result(result1)
`ifdef SHIFT_CARRY_EN
    , .carry_out(carry1)
`endif
  );

  shift_rotate_unit #(.WIDTH(WIDTH), .STEP(4)) u_dut4 (
    .Clock(Clock), .Clear(Clear), .start(start), .op(op), .operand(operand),
    .amount(amount), .busy(busy4), .done(done4), .result(result4)
`ifdef SHIFT_CARRY_EN
    , .carry_out(carry4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation, watch both instances for 36 cycles, optionally pulse a
  // second start at cycle pulse_at while they are busy.
  task automatic run_vec(input string tag, input logic [2:0] o, input logic [31:0] opd,
                         input logic [31:0] amt, input logic [31:0] exp_res,
                         input int exp_lat1, input int exp_lat4, input logic exp_cy,
                         input int pulse_at);
    int lat1, lat4, pulses1, pulses4, busy_cnt1;
    logic [31:0] res1, res4;
    logic cy1, cy4;
    lat1 = 0; lat4 = 0; pulses1 = 0; pulses4 = 0; busy_cnt1 = 0;
    res1 = '0; res4 = '0; cy1 = 1'b0; cy4 = 1'b0;
    op = o; operand = opd; amount = amt; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0; operand = ~opd; amount = 32'd3;
    for (int c = 1; c <= 36; c++) begin
      if (done1) begin
        pulses1++;
        if (lat1 == 0) begin
          lat1 = c; res1 = result1;
`ifdef SHIFT_CARRY_EN
          cy1 = carry1;
`endif
        end
      end
      if (done4) begin
        pulses4++;
        if (lat4 == 0) begin
          lat4 = c; res4 = result4;
`ifdef SHIFT_CARRY_EN
          cy4 = carry4;
`endif
        end
      end
      if (busy1) busy_cnt1++;
      if (c == pulse_at) begin
        start = 1'b1; op = OP_SHL; operand = 32'hAAAAAAAA; amount = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge Clock); #1;
    end
    check({tag, ".res1"}, 64'(res1), 64'(exp_res));
    check({tag, ".lat1"}, 64'(lat1), 64'(exp_lat1));
    check({tag, ".busy1"}, 64'(busy_cnt1), 64'(exp_lat1));
    check({tag, ".pulses1"}, 64'(pulses1), 64'd1);
    check({tag, ".res4"}, 64'(res4), 64'(exp_res));
    check({tag, ".lat4"}, 64'(lat4), 64'(exp_lat4));
    check({tag, ".pulses4"}, 64'(pulses4), 64'd1);
    check({tag, ".held1"}, 64'(result1), 64'(exp_res));
    check({tag, ".idle"}, 64'({busy1, busy4}), 64'd0);
`ifdef SHIFT_CARRY_EN
    check({tag, ".cy1"}, 64'(cy1), 64'(exp_cy));
    check({tag, ".cy4"}, 64'(cy4), 64'(exp_cy));
`else
    if (exp_cy !== cy1 && cy1 !== cy4) check({tag, ".cy"}, 64'(cy1), 64'(cy4));
`endif
  endtask

  task automatic clear_mid_shift();
    int pulses;
    pulses = 0;
    op = OP_SHR; operand = 32'hFFFFFFFF; amount = 32'd20; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    repeat (3) begin @(posedge Clock); #1; end
    check("clr.pre_busy", 64'({busy1, busy4}), 64'd3);
    Clear = 1'b1;
    #1;
    check("clr.busy", 64'({busy1, busy4}), 64'd0);
    check("clr.done", 64'({done1, done4}), 64'd0);
    check("clr.res1", 64'(result1), 64'd0);
    check("clr.res4", 64'(result4), 64'd0);
    @(posedge Clock); #1;
    Clear = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done1 || done4) pulses++;
      @(posedge Clock); #1;
    end
    check("clr.no_done", 64'(pulses), 64'd0);
  endtask

  initial begin
    Clear = 1'b1; start = 1'b0; op = '0; operand = '0; amount = '0;
    #1;
    check("rst.busy", 64'({busy1, busy4}), 64'd0);
    check("rst.done", 64'({done1, done4}), 64'd0);
    check("rst.res", 64'({result1, result4}), 64'd0);
`ifdef SHIFT_CARRY_EN
    check("rst.cy", 64'({carry1, carry4}), 64'd0);
`endif
    @(posedge Clock); #1;
    Clear = 1'b0;
    @(posedge Clock); #1;

    //       tag         op        operand        amount  result         l1  l4 cy  pulse
    run_vec("ror8",    OP_ROR,  32'h00000014, 32'd8,  32'h14000000,  9,  3, 1'b0, 0);
    run_vec("rol33",   OP_ROL,  32'h80000001, 32'd33, 32'h00000003,  2,  2, 1'b1, 0);
    run_vec("shl33",   OP_SHL,  32'h0000000B, 32'd33, 32'h00000000, 33,  9, 1'b1, 0);
    run_vec("shra40",  OP_SHRA, 32'h80000000, 32'd40, 32'hFFFFFFFF, 33,  9, 1'b1, 0);
    run_vec("shr40",   OP_SHR,  32'h80000000, 32'd40, 32'h00000000, 33,  9, 1'b1, 0);
    run_vec("shr2",    OP_SHR,  32'h0000000B, 32'd2,  32'h00000002,  3,  2, 1'b1, 0);
    run_vec("ror0",    OP_ROR,  32'h12345678, 32'd0,  32'h12345678,  1,  1, 1'b0, 0);
    run_vec("pass",    3'b111,  32'hDEADBEEF, 32'd5,  32'hDEADBEEF,  1,  1, 1'b0, 0);
    run_vec("shra4",   OP_SHRA, 32'hF0000000, 32'd4,  32'hFF000000,  5,  2, 1'b0, 0);
    run_vec("shl4",    OP_SHL,  32'hF0000001, 32'd4,  32'h00000010,  5,  2, 1'b1, 0);
    run_vec("rol8",    OP_ROL,  32'h12345678, 32'd8,  32'h34567812,  9,  3, 1'b0, 0);
    run_vec("ror36",   OP_ROR,  32'h12345678, 32'd36, 32'h81234567,  5,  2, 1'b1, 0);
    run_vec("ror16bz", OP_ROR,  32'h0000FFFF, 32'd16, 32'hFFFF0000, 17,  5, 1'b1, 3);
    clear_mid_shift();
    run_vec("post_clr", OP_ROR, 32'h00000014, 32'd8,  32'h14000000,  9,  3, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
